// File: rtl/fc_neuron_stream.sv
// rtl/fc_neuron_stream.sv - streaming fixed-point fully-connected neuron with bias, activation and saturation
`timescale 1ns/1ps

module fc_neuron_stream #(
   parameter int IN_SIZE = 64,
   parameter int LANES   = 16,
   parameter int DWIDTH  = 16,
   parameter int FRAC    = 8,
   parameter int ACC_W   = 40
) (
   input  logic                     clk,
   input  logic                     nreset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DWIDTH*LANES-1:0]  in_data,
   input  logic [DWIDTH*LANES-1:0]  weight,
   input  logic [DWIDTH-1:0]        bias,
   input  logic [1:0]               act_mode,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DWIDTH-1:0]        out_data,
   output logic                     out_sat,
   output logic                     busy
);

   localparam int BEATS  = IN_SIZE / LANES;
   localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TREE_N = 1 << $clog2(LANES);
   localparam int PROD_W = 2 * DWIDTH;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   // Saturation bounds expressed at accumulator width
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      FINISH = 2'd2,
      OUT    = 2'd3
   } state_t;

   state_t                    state_q;
   state_t                    state_d;
   logic                      in_ready_q;
   logic [CNT_W-1:0]          cnt_q;
   logic signed [ACC_W-1:0]   acc_q;
   logic signed [DWIDTH-1:0]  bias_q;
   logic [1:0]                mode_q;
   logic [DWIDTH-1:0]         out_data_q;
   logic                      out_sat_q;

   logic                      accept;

   // Per-lane products and the reduction tree (heap layout: leaves at TREE_N-1..)
   logic signed [DWIDTH-1:0]  lane_d;
   logic signed [DWIDTH-1:0]  lane_w;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   node [0:2*TREE_N-2];
   logic signed [ACC_W-1:0]   beat_sum;

   // Finishing arithmetic
   logic signed [ACC_W-1:0]   fin_sum;
   logic signed [ACC_W-1:0]   act_val;
   logic [DWIDTH-1:0]         res_data;
   logic                      res_sat;

   assign accept    = in_valid && in_ready_q;
   assign in_ready  = in_ready_q;
   assign out_valid = (state_q == OUT);
   assign busy      = (state_q != IDLE);
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

   // Multiply every lane, rescale by FRAC (floor), widen and reduce through a balanced adder tree
   always_comb begin
      lane_d = '0;
      lane_w = '0;
      prod   = '0;
      for (int i = 0; i < 2*TREE_N-1; i++) begin
         node[i] = '0;
      end
      for (int k = 0; k < LANES; k++) begin
         lane_d = in_data[k*DWIDTH +: DWIDTH];
         lane_w = weight[k*DWIDTH +: DWIDTH];
         prod   = PROD_W'(lane_d) * PROD_W'(lane_w);
         node[TREE_N-1+k] = ACC_W'(prod >>> FRAC);
      end
      for (int i = TREE_N-2; i >= 0; i--) begin
         node[i] = node[2*i+1] + node[2*i+2];
      end
      beat_sum = node[0];
   end

   // Bias add, selectable activation at full width, then clamp to the output range
   always_comb begin
      fin_sum = acc_q + ACC_W'(bias_q);
      case (mode_q)
         2'd0:    act_val = fin_sum;
         2'd2:    act_val = fin_sum[ACC_W-1] ? (fin_sum >>> 3) : fin_sum;
         default: act_val = fin_sum[ACC_W-1] ? '0 : fin_sum;
      endcase
      if (act_val > SAT_MAX) begin
         res_data = SAT_MAX[DWIDTH-1:0];
         res_sat  = 1'b1;
      end else if (act_val < SAT_MIN) begin
         res_data = SAT_MIN[DWIDTH-1:0];
         res_sat  = 1'b1;
      end else begin
         res_data = act_val[DWIDTH-1:0];
         res_sat  = 1'b0;
      end
   end

   // Next-state logic for the dot-product sequencer
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = (BEATS == 1) ? FINISH : ACCUM;
            end
         end
         ACCUM: begin
            if (accept && (cnt_q == LAST_CNT)) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            state_d = OUT;
         end
         OUT: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; in_ready is registered from the next state so it never follows in_valid
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d == IDLE) || (state_d == ACCUM);
      end
   end

   // Accumulator, beat counter, first-beat parameter capture and result register
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         bias_q     <= '0;
         mode_q     <= '0;
         out_data_q <= '0;
         out_sat_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  acc_q  <= acc_q + beat_sum;
                  bias_q <= bias;
                  mode_q <= act_mode;
                  cnt_q  <= CNT_W'(1);
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc_q <= acc_q + beat_sum;
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            FINISH: begin
               out_data_q <= res_data;
               out_sat_q  <= res_sat;
               acc_q      <= '0;
               cnt_q      <= '0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/fc_neuron_stream.md
# fc_neuron_stream

Second-generation fully-connected neuron for the FC accelerator IP. It consumes one dot product of IN_SIZE signed fixed-point operands as a stream of LANES-wide beats under a valid/ready handshake, and accumulates into a wide accumulator. It then adds a bias, applies a run-time-selectable activation, saturates to DWIDTH and presents the result on a back-pressurable output port. It sits between the AXI-side input/weight buffers and the layer result buffer, replacing the fixed-16-lane, ReLU-only, non-saturating neuron.

## Interface
- IN_SIZE, 64, operands per dot product; must be a multiple of LANES.
- LANES, 16, multiply lanes per beat (1..64).
- DWIDTH, 16, signed two's-complement width of data, weight, bias and result.
- FRAC, 8, fractional bits of every operand and of the result (0 ≤ FRAC < DWIDTH).
- ACC_W, 40, accumulator width; must be ≥ 2*DWIDTH-FRAC+clog2(IN_SIZE).
- clk  in  1  sole clock, all state on rising edge.
- nreset  in  1  asynchronous, active-low reset.
- in_valid  in  1  a beat is presented.
- in_ready  out  1  the block accepts a beat this cycle.
- in_data  in  DWIDTH*LANES  lane k = bits [(k+1)*DWIDTH-1 : k*DWIDTH].
- weight  in  DWIDTH*LANES  same lane packing as in_data.
- bias  in  DWIDTH  sampled on the first beat of a dot product.
- act_mode  in  2  sampled on the first beat: 0 = none, 1 = ReLU, 2 = leaky ReLU (x>>>3), 3 = ReLU.
- out_valid  out  1  result held valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DWIDTH  activated, saturated result.
- out_sat  out  1  saturation occurred on this result; qualified by out_valid.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ACCUM, FINISH, OUT.
- IDLE: in_ready=1, acc=0, beat counter=0. An accepted beat (in_valid&&in_ready) latches bias and act_mode, accumulates, and moves to ACCUM. If BEATS=IN_SIZE/LANES equals 1, it moves directly to FINISH.
- ACCUM: in_ready=1. Each accepted beat accumulates and increments the counter. The BEATS-th accepted beat moves the FSM to FINISH. in_valid low stalls with no state change.
- Per-lane product: signed DWIDTH×DWIDTH → 2*DWIDTH, then arithmetic shift right by FRAC (truncation toward −∞). The product is sign-extended to ACC_W. All lanes are summed by an adder tree and added into acc. There is no saturation inside the accumulation.
- FINISH (1 cycle): in_ready=0. sum = acc + sign-extended bias. The activation is applied to sum at ACC_W: ReLU gives max(sum,0); leaky gives sum>>>3 when sum<0. The result is then saturated to [−2^(DWIDTH−1), 2^(DWIDTH−1)−1]. The output register and out_sat are loaded, acc is cleared, and the FSM moves to OUT.
- OUT: in_ready=0, out_valid=1, out_data/out_sat stable. When out_ready=1, the FSM moves to IDLE. Input beats presented during OUT are not accepted.
- Reset, including mid-dot-product: all state is cleared immediately. The partial accumulation is discarded, and the next accepted beat starts a new dot product.

## Timing
- Reset values: in_ready=0 while nreset=0 and 1 in IDLE after release; out_valid=0, out_data=0, out_sat=0, busy=0.
- in_ready is a registered function of the state only. It never depends combinationally on in_valid.
- Latency: last beat accepted at edge t → out_valid=1 after edge t+1 (FINISH at t+1, OUT visible from t+1).
- out_valid, once high, stays high with stable data until an edge where out_ready=1. It deasserts after that edge.
- Earliest next beat: the cycle after the out handshake edge. Steady-state throughput is BEATS+2 cycles per result with out_ready held high.
- out_ready has no effect outside OUT.

## Test plan
DWIDTH=16, FRAC=8, LANES=4, IN_SIZE=8 (2 beats), 1.0=256:
- All data=256, weights=256, bias=0, mode 1 → out_data=2048, out_sat=0, out_valid one cycle after the second beat.
- Weights=−256, bias=0; modes 0/1/2 → out_data=−2048 / 0 / −256, out_sat=0.
- data=weights=32767, bias=0, mode 0 → out_data=32767, out_sat=1. With data=32767, weights=−32768 → out_data=−32768, out_sat=1.
- Stalls: in_valid toggled 1-0-0-1 with data=256, weights=256, bias=256 (1.0), mode 1 → out_data=2304. Hold out_ready=0 for 5 cycles → out_valid and out_data stable, in_ready=0. Release → in_ready=1 on the next cycle.
- Assert nreset after the first beat → all outputs at reset values. Then 2 fresh beats (as in test 1) → out_data=2048, with no residue from the aborted beat.
- Back-to-back 3 dot products with out_ready=1 → results spaced exactly BEATS+2=4 cycles apart, and bias/act_mode changed on each first beat are honoured.
